spi_bus_arbiter: RTL and testbench

Shares the single spi_master instance (one SCLK/SDIO pair) between the AD9517, ADC0 and ADC1 configuration sequencers. It replaces the hard-wired cfg_go mux with round-robin arbitration and per-device chip-select routing. It also drains in-flight transfers before handing the bus over, and flags protocol violations. It sits between the *_cfg blocks and spi_master, in the clk_20m domain.

---
 rtl/spi_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared spi_master: routes commands, data and chip-select to one sequencer at a time.
// Optional idle-grant watchdog is built in when SPI_ARB_TIMEOUT_EN is defined.
module spi_bus_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int GAP_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 i_req,
  output logic [NUM_REQ-1:0]                 o_gnt,
  input  logic [NUM_REQ-1:0]                 i_wr_cmd,
  input  logic [NUM_REQ-1:0]                 i_rd_cmd,
  input  logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] i_wr_data,
  output logic [NUM_REQ-1:0]                 o_busy,
  output logic [MISO_DATA_WIDTH:0]           o_rd_data,
  output logic                               o_spi_wr_cmd,
  output logic                               o_spi_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]         o_spi_wr_data,
  input  logic                               i_spi_busy,
  input  logic [MISO_DATA_WIDTH:0]           i_spi_rd_data,
  input  logic                               i_spi_cs_n,
  output logic [NUM_REQ-1:0]                 o_cs_n,
  output logic                               o_err,
  output logic [1:0]                         o_owner
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_t;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t                     state;
  logic [1:0]                 rr_ptr;
  logic [GAP_W-1:0]           gap_cnt;
  logic [NUM_REQ-1:0]         own_mask;
  logic [NUM_REQ-1:0]         eligible;
  logic [NUM_REQ-1:0]         foreign;
  logic [NUM_REQ-1:0]         win_onehot;
  logic [MOSI_DATA_WIDTH-1:0] owner_data;
  logic [1:0]                 win;
  logic [1:0]                 next_ptr;
  logic                       win_valid;
  logic                       own_wr;
  logic                       own_rd;
  logic                       owner_req;
  logic                       in_grant;
  logic                       err_now;
  logic                       timeout_hit;

  always_comb begin
    own_mask   = '0;
    win_onehot = '0;
    owner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      own_mask[k]   = (o_owner == 2'(k));
      win_onehot[k] = (win == 2'(k));
      if (o_owner == 2'(k))
        owner_data = i_wr_data[k*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
    end
  end

  // Scan downward so the eligible requester closest to rr_ptr is written last and wins.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[(int'(rr_ptr) + i) % NUM_REQ]) begin
        win       = 2'((int'(rr_ptr) + i) % NUM_REQ);
        win_valid = 1'b1;
      end
    end
    next_ptr = (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
  end

  assign in_grant  = (state == GRANT);
  assign own_wr    = |(i_wr_cmd & own_mask);
  assign own_rd    = |(i_rd_cmd & own_mask);
  assign owner_req = |(i_req & own_mask);
  assign foreign   = in_grant ? ((i_wr_cmd | i_rd_cmd) & ~own_mask) : (i_wr_cmd | i_rd_cmd);
  assign err_now   = (|foreign) || timeout_hit ||
                     (in_grant && (((own_wr || own_rd) && i_spi_busy) || (own_wr && own_rd)));

  always_comb begin
    o_spi_wr_cmd  = in_grant && own_wr;
    o_spi_rd_cmd  = in_grant && own_rd && !own_wr;
    o_spi_wr_data = in_grant ? owner_data : '0;
    o_rd_data     = i_spi_rd_data;
    o_cs_n        = '1;
    o_busy        = '1;
    if (in_grant || state == DRAIN)
      o_cs_n = ~own_mask | {NUM_REQ{i_spi_cs_n}};
    if (in_grant)
      o_busy = ~own_mask | {NUM_REQ{i_spi_busy}};
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]        wd_cnt;
  logic [NUM_REQ-1:0] blocked;
  logic               grant_idle;

  assign grant_idle  = in_grant && owner_req && !i_spi_busy && !own_wr && !own_rd;
  assign timeout_hit = grant_idle && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign eligible    = i_req & ~blocked;

  // A timed-out requester stays locked out until it lets go of its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      blocked <= '0;
    end else begin
      blocked <= (blocked & i_req) | (timeout_hit ? own_mask : '0);
      wd_cnt  <= (grant_idle && !timeout_hit) ? wd_cnt + 16'd1 : '0;
    end
  end
`else
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign eligible    = i_req;
`endif

  // The final GAP cycle arbitrates directly, so ownership changes see exactly GAP_CYCLES idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      o_gnt   <= '0;
      o_owner <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      o_err   <= 1'b0;
    end else begin
      if (err_now)
        o_err <= 1'b1;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= GRANT;
            o_gnt   <= win_onehot;
            o_owner <= win;
            rr_ptr  <= next_ptr;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state   <= i_spi_busy ? DRAIN : GAP;
            o_gnt   <= '0;
            gap_cnt <= '0;
          end else if (timeout_hit) begin
            state   <= GAP;
            o_gnt   <= '0;
            gap_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!i_spi_busy) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (win_valid) begin
              state   <= GRANT;
              o_gnt   <= win_onehot;
              o_owner <= win;
              rr_ptr  <= next_ptr;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: randomized contention against a round-robin reference model,
// plus directed reset, drain, illegal-command and async-reset scenarios.
module tb_spi_bus_arbiter;

  localparam int NUM_REQ = 3;
  localparam int MOSI_W  = 24;
  localparam int MISO_W  = 8;
  localparam int RDW     = MISO_W + 1;
  localparam int GAP     = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req, wr_cmd, rd_cmd;
  logic [NUM_REQ*MOSI_W-1:0]  wr_data;
  logic                       spi_busy, spi_cs_n;
  logic [MISO_W:0]            spi_rd_data;
  logic [NUM_REQ-1:0]         gnt, busy, cs_n;
  logic [MISO_W:0]            rd_data;
  logic                       spi_wr_cmd, spi_rd_cmd, err;
  logic [MOSI_W-1:0]          spi_wr_data;
  logic [1:0]                 owner;

  int checks   = 0;
  int errors   = 0;
  int rr_model = 0;

  spi_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .MOSI_DATA_WIDTH(MOSI_W), .MISO_DATA_WIDTH(MISO_W),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(65535)
  ) dut (
    .clk(clk), .rst(rst), .i_req(req), .o_gnt(gnt), .i_wr_cmd(wr_cmd), .i_rd_cmd(rd_cmd),
    .i_wr_data(wr_data), .o_busy(busy), .o_rd_data(rd_data), .o_spi_wr_cmd(spi_wr_cmd),
    .o_spi_rd_cmd(spi_rd_cmd), .o_spi_wr_data(spi_wr_data), .i_spi_busy(spi_busy),
    .i_spi_rd_data(spi_rd_data), .i_spi_cs_n(spi_cs_n), .o_cs_n(cs_n), .o_err(err), .o_owner(owner)
  );

  always #5 clk = ~clk;

  // Reference arbitration: first requester found scanning upward from the pointer, wrapping around.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int i = 0; i < NUM_REQ; i++)
      if (r[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
    int idx = -1;
    int n   = 0;
    for (int i = 0; i < NUM_REQ; i++)
      if (g[i]) begin idx = i; n++; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] routed(input int w, input logic bit_val);
    logic [NUM_REQ-1:0] m = '1;
    m[w] = bit_val;
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; wr_cmd = '0; rd_cmd = '0; wr_data = '0;
    spi_busy = 1'b0; spi_cs_n = 1'b1; spi_rd_data = '0;
    rr_model = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int idx, output int idle, output int cs_bad);
    bit done = 1'b0;
    idx = -1; idle = 0; cs_bad = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (gnt !== '0) begin
        idx  = onehot_idx(gnt);
        done = 1'b1;
      end else begin
        idle++;
        if (cs_n !== '1) cs_bad++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    req = 3'b111; wr_cmd = 3'b001;
    rst = 1'b1; #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (cs_n !== 3'b111) begin errors++; $display("[TB] FAIL reset_cs_n: got %b expected 111", cs_n); end
    checks++; if (busy !== 3'b111) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 111", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (owner !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner); end
    checks++;
    if (spi_wr_cmd !== 1'b0 || spi_rd_cmd !== 1'b0 || spi_wr_data !== '0) begin
      errors++; $display("[TB] FAIL reset_spi_cmd: got wr=%b rd=%b data=%h expected 0/0/0", spi_wr_cmd, spi_rd_cmd, spi_wr_data);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_hold_gnt: got %b expected 000", gnt); end
    rst = 1'b0; req = '0; wr_cmd = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010; #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL single_latency: got %b expected 000", gnt); end
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010 || owner !== 2'd1) begin errors++; $display("[TB] FAIL single_grant: got gnt=%b owner=%0d expected 010/1", gnt, owner); end
    wr_data = '0; wr_data[1*MOSI_W +: MOSI_W] = 24'h000518; wr_cmd = 3'b010; #1;
    checks++;
    if (spi_wr_cmd !== 1'b1 || spi_wr_data !== 24'h000518) begin
      errors++; $display("[TB] FAIL single_write: got cmd=%b data=%h expected 1/000518", spi_wr_cmd, spi_wr_data);
    end
    checks++; if (cs_n !== 3'b111 || busy !== 3'b101) begin errors++; $display("[TB] FAIL single_idle_view: got cs_n=%b busy=%b expected 111/101", cs_n, busy); end
    @(negedge clk);
    wr_cmd = '0; spi_busy = 1'b1; spi_cs_n = 1'b0; spi_rd_data = 9'h1A5; #1;
    checks++; if (cs_n !== 3'b101 || busy !== 3'b111) begin errors++; $display("[TB] FAIL single_cs_route: got cs_n=%b busy=%b expected 101/111", cs_n, busy); end
    checks++; if (rd_data !== 9'h1A5) begin errors++; $display("[TB] FAIL single_rd_data: got %h expected 1a5", rd_data); end
    @(negedge clk);
    spi_busy = 1'b0; spi_cs_n = 1'b1; rd_cmd = 3'b010; #1;
    checks++; if (spi_rd_cmd !== 1'b1 || spi_wr_cmd !== 1'b0) begin errors++; $display("[TB] FAIL single_read: got rd=%b wr=%b expected 1/0", spi_rd_cmd, spi_wr_cmd); end
    @(negedge clk);
    rd_cmd = '0; req = '0;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b000 || err !== 1'b0) begin errors++; $display("[TB] FAIL single_release: got gnt=%b err=%b expected 000/0", gnt, err); end
    repeat (GAP + 1) @(negedge clk);
  endtask

  task automatic test_contention();
    int w, idle, csb, gb, exp_w, blen, dlen;
    bit drain;
    logic [NUM_REQ-1:0] nxt;
    do_reset();
    req = 3'b111;
    wait_grant(w, idle, csb);
    checks++; if (idle != 0) begin errors++; $display("[TB] FAIL first_grant_latency: got %0d idle cycles expected 0", idle); end
    for (int r = 0; r < 16; r++) begin
      exp_w = rr_pick(req, rr_model);
      checks++; if (w != exp_w) begin errors++; $display("[TB] FAIL grant_order round %0d: got %0d expected %0d", r, w, exp_w); end
      if (w < 0 || w != exp_w) break;
      rr_model = (exp_w + 1) % NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) wr_data[k*MOSI_W +: MOSI_W] = MOSI_W'($urandom);
      spi_rd_data = RDW'($urandom);
      wr_cmd = '0; wr_cmd[w] = 1'b1; #1;
      checks++;
      if (spi_wr_cmd !== 1'b1 || spi_wr_data !== wr_data[w*MOSI_W +: MOSI_W]) begin
        errors++; $display("[TB] FAIL pass_through owner %0d: got cmd=%b data=%h expected 1/%h", w, spi_wr_cmd, spi_wr_data, wr_data[w*MOSI_W +: MOSI_W]);
      end
      checks++; if (busy !== routed(w, 1'b0)) begin errors++; $display("[TB] FAIL busy_view owner %0d: got %b expected %b", w, busy, routed(w, 1'b0)); end
      checks++; if (rd_data !== spi_rd_data) begin errors++; $display("[TB] FAIL rd_broadcast: got %h expected %h", rd_data, spi_rd_data); end
      @(negedge clk);
      wr_cmd = '0; spi_busy = 1'b1; spi_cs_n = 1'b0; #1;
      checks++; if (cs_n !== routed(w, 1'b0)) begin errors++; $display("[TB] FAIL cs_route owner %0d: got %b expected %b", w, cs_n, routed(w, 1'b0)); end
      blen  = $urandom_range(0, 3);
      repeat (blen) @(negedge clk);
      drain = 1'($urandom_range(0, 1));
      nxt   = (r < 3) ? 3'b111 : NUM_REQ'($urandom_range(1, 7));
      if (drain) begin
        @(negedge clk);
        req[w] = 1'b0;
        dlen = $urandom_range(1, 6);
        csb = 0; gb = 0;
        for (int i = 0; i < dlen; i++) begin
          @(negedge clk); #1;
          if (gnt !== '0) gb++;
          if (cs_n !== routed(w, 1'b0)) csb++;
          if (i == 0) req = nxt;
        end
        checks++; if (gb != 0 || csb != 0) begin errors++; $display("[TB] FAIL drain_route owner %0d: got %0d grant and %0d cs errors expected 0/0", w, gb, csb); end
        @(negedge clk);
        spi_busy = 1'b0; spi_cs_n = 1'b1;
        wait_grant(w, idle, csb);
        checks++; if (idle != GAP || csb != 0) begin errors++; $display("[TB] FAIL gap_after_drain: got idle=%0d cs_errs=%0d expected %0d/0", idle, csb, GAP); end
      end else begin
        @(negedge clk);
        spi_busy = 1'b0; spi_cs_n = 1'b1;
        @(negedge clk);
        req[w] = 1'b0;
        @(negedge clk); #1;
        checks++; if (gnt !== '0 || cs_n !== '1) begin errors++; $display("[TB] FAIL release_drop: got gnt=%b cs_n=%b expected 000/111", gnt, cs_n); end
        req = nxt;
        wait_grant(w, idle, csb);
        checks++; if (idle != GAP - 1 || csb != 0) begin errors++; $display("[TB] FAIL gap_after_release: got idle=%0d cs_errs=%0d expected %0d/0", idle + 1, csb, GAP); end
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL contention_err: got %b expected 0", err); end
  endtask

  task automatic test_drain30();
    int w, idle, csb, gb;
    do_reset();
    req = 3'b001;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL drain30_grant: got %b expected 001", gnt); end
    rr_model = 1;
    wr_cmd = 3'b001;
    @(negedge clk);
    wr_cmd = '0; spi_busy = 1'b1; spi_cs_n = 1'b0; req = '0;
    csb = 0; gb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (gnt !== '0) gb++;
      if (cs_n !== 3'b110) csb++;
      if (i == 0) req = 3'b010;
    end
    checks++; if (gb != 0 || csb != 0) begin errors++; $display("[TB] FAIL drain30_route: got %0d grant and %0d cs errors expected 0/0", gb, csb); end
    @(negedge clk);
    spi_busy = 1'b0; spi_cs_n = 1'b1;
    wait_grant(w, idle, csb);
    checks++; if (w != rr_pick(req, rr_model) || idle != GAP) begin errors++; $display("[TB] FAIL drain30_next: got owner=%0d idle=%0d expected %0d/%0d", w, idle, rr_pick(req, rr_model), GAP); end
  endtask

  task automatic test_illegal();
    int sticky_bad;
    for (int kind = 0; kind < 3; kind++) begin
      do_reset();
      req = 3'b001;
      @(negedge clk); #1;
      if (kind == 0) begin
        wr_cmd = NUM_REQ'(1 << $urandom_range(1, 2)); #1;
        checks++; if (spi_wr_cmd !== 1'b0) begin errors++; $display("[TB] FAIL foreign_dropped: got %b expected 0", spi_wr_cmd); end
      end else if (kind == 1) begin
        spi_busy = 1'b1; wr_cmd = 3'b001; #1;
      end else begin
        wr_cmd = 3'b001; rd_cmd = 3'b001; #1;
        checks++; if (spi_wr_cmd !== 1'b1 || spi_rd_cmd !== 1'b0) begin errors++; $display("[TB] FAIL wr_wins: got wr=%b rd=%b expected 1/0", spi_wr_cmd, spi_rd_cmd); end
      end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_before_edge kind %0d: got %b expected 0", kind, err); end
      @(negedge clk);
      wr_cmd = '0; rd_cmd = '0; spi_busy = 1'b0; #1;
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set kind %0d: got %b expected 1", kind, err); end
      req = '0;
      sticky_bad = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); #1;
        if (err !== 1'b1) sticky_bad++;
      end
      checks++; if (sticky_bad != 0) begin errors++; $display("[TB] FAIL err_sticky kind %0d: got %0d cleared cycles expected 0", kind, sticky_bad); end
    end
    do_reset(); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared_by_rst: got %b expected 0", err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 3'b010;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL async_pre_grant: got %b expected 010", gnt); end
    spi_cs_n = 1'b0; #1;
    checks++; if (cs_n !== 3'b101) begin errors++; $display("[TB] FAIL async_pre_cs: got %b expected 101", cs_n); end
    rst = 1'b1; #1;
    checks++; if (gnt !== 3'b000 || cs_n !== 3'b111) begin errors++; $display("[TB] FAIL async_abort: got gnt=%b cs_n=%b expected 000/111", gnt, cs_n); end
    @(negedge clk);
    rst = 1'b0; spi_cs_n = 1'b1; req = 3'b101; rr_model = 0;
    @(negedge clk); #1;
    checks++; if (onehot_idx(gnt) != rr_pick(req, rr_model)) begin errors++; $display("[TB] FAIL async_rr_restart: got gnt=%b expected index %0d", gnt, rr_pick(req, rr_model)); end
    do_reset();
    req = 3'b100;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b100 || owner !== 2'd2) begin errors++; $display("[TB] FAIL async_regrant: got gnt=%b owner=%0d expected 100/2", gnt, owner); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_drain30();
    test_illegal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
